// File: rtl/ulpb_tx_arbiter_pkg.sv
// ulpb_tx_arbiter_pkg: shared state encodings and width helper for the ULPB transmit arbiter.
package ulpb_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQUEST,
        ARB_WAIT_RESULT,
        ARB_BACKOFF
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int ulpb_log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/ulpb_tx_arbiter_rr_picker.sv
// ulpb_rr_picker: combinational round-robin pick of the first set request at or above ptr, wrapping.
module ulpb_rr_picker
    import ulpb_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);

    logic [PTR_W-1:0] j;

    // Scanning the offsets downward lets the nearest request to ptr win.
    always_comb begin
        valid = |req;
        idx = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) idx = j;
        end
        gnt = valid ? NUM_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/ulpb_tx_arbiter.sv
// ulpb_tx_arbiter: round-robin sharing of one ULPB transmit port, with retry/backoff on lost arbitration.
module ulpb_tx_arbiter
    import ulpb_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic                          CLK_IN,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            DONE,
    output logic [NUM_REQ-1:0]            FAIL,
    output logic                          TX_REQ,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    input  logic                          TX_ACK,
    input  logic                          ARB_LOST,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    input  logic                          BUS_RESET
);

    localparam int PTR_W = ulpb_log2(NUM_REQ);
    localparam int RTY_W = ulpb_log2(MAX_RETRY + 1);
    localparam int BO_W  = ulpb_log2(BACKOFF_CYCLES);

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [RTY_W-1:0]   retry_cnt;
    logic [BO_W-1:0]    backoff_cnt;
    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;

    ulpb_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req   (REQ),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    assign next_ptr = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // DONE/FAIL default low so every finish produces exactly a one-cycle pulse.
    always_ff @(posedge CLK_IN) begin
        DONE <= '0;
        FAIL <= '0;
        if (RESET) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            retry_cnt   <= '0;
            backoff_cnt <= '0;
            GNT         <= '0;
            TX_REQ      <= 1'b0;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
        end else if (state != ARB_IDLE && BUS_RESET) begin
            state  <= ARB_IDLE;
            GNT    <= '0;
            FAIL   <= GNT;
            TX_REQ <= 1'b0;
            rr_ptr <= next_ptr;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid && !BUS_RESET) begin
                        state     <= ARB_REQUEST;
                        gnt_idx   <= pick_idx;
                        GNT       <= pick_gnt;
                        TX_ADDR   <= REQ_ADDR[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        TX_DATA   <= REQ_DATA[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        retry_cnt <= '0;
                        TX_REQ    <= 1'b1;
                    end
                end
                ARB_REQUEST: begin
                    if (ARB_LOST) begin
                        TX_REQ <= 1'b0;
                        if (retry_cnt == RTY_W'(MAX_RETRY)) begin
                            state  <= ARB_IDLE;
                            GNT    <= '0;
                            FAIL   <= GNT;
                            rr_ptr <= next_ptr;
                        end else begin
                            state       <= ARB_BACKOFF;
                            retry_cnt   <= retry_cnt + 1'b1;
                            backoff_cnt <= BO_W'(BACKOFF_CYCLES - 1);
                        end
                    end else if (TX_ACK) begin
                        TX_REQ <= 1'b0;
                        state  <= ARB_WAIT_RESULT;
                    end else if (!REQ[gnt_idx]) begin
                        TX_REQ <= 1'b0;
                        GNT    <= '0;
                        state  <= ARB_IDLE;
                    end
                end
                ARB_WAIT_RESULT: begin
                    if (TX_FAIL || TX_SUCC) begin
                        state  <= ARB_IDLE;
                        GNT    <= '0;
                        FAIL   <= TX_FAIL ? GNT : '0;
                        DONE   <= TX_FAIL ? '0 : GNT;
                        rr_ptr <= next_ptr;
                    end
                end
                ARB_BACKOFF: begin
                    if (!REQ[gnt_idx]) begin
                        GNT   <= '0;
                        state <= ARB_IDLE;
                    end else if (backoff_cnt == '0) begin
                        state  <= ARB_REQUEST;
                        TX_REQ <= 1'b1;
                    end else begin
                        backoff_cnt <= backoff_cnt - 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// tb_ulpb_tx_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_ulpb_tx_arbiter;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MR = 3;
    localparam int BO = 16;

    logic            CLK_IN = 1'b0;
    logic            RESET;
    logic [N-1:0]    REQ;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N*DW-1:0] REQ_DATA;
    logic [N-1:0]    GNT, DONE, FAIL;
    logic            TX_REQ;
    logic [AW-1:0]   TX_ADDR;
    logic [DW-1:0]   TX_DATA;
    logic            TX_ACK, ARB_LOST, TX_SUCC, TX_FAIL, BUS_RESET;

    int checks = 0;
    int errors = 0;

    ulpb_tx_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MR), .BACKOFF_CYCLES(BO)) dut (
        .CLK_IN(CLK_IN), .RESET(RESET), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .GNT(GNT), .DONE(DONE), .FAIL(FAIL), .TX_REQ(TX_REQ), .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA),
        .TX_ACK(TX_ACK), .ARB_LOST(ARB_LOST), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .BUS_RESET(BUS_RESET)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port, how many attempts were lost,
    // how many quiet cycles remain, and whether the bus result is awaited.
    int           m_owner = -1;
    int           m_ptr = 0;
    int           m_lost = 0;
    int           m_hold = 0;
    bit           m_wait = 0;
    logic [N-1:0] e_gnt = '0, e_done = '0, e_fail = '0;
    logic         e_txreq = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;

    task automatic m_finish(input bit failed);
        if (failed) e_fail = N'(1) << m_owner;
        else e_done = N'(1) << m_owner;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        e_txreq = 1'b0;
    endtask

    task automatic m_withdraw();
        m_owner = -1;
        e_txreq = 1'b0;
    endtask

    always @(posedge CLK_IN) begin
        e_done = '0;
        e_fail = '0;
        if (RESET) begin
            m_owner = -1; m_ptr = 0; m_lost = 0; m_hold = 0; m_wait = 0;
            e_txreq = 1'b0; e_addr = '0; e_data = '0;
        end else if (m_owner < 0) begin
            if (!BUS_RESET && REQ != '0) begin
                for (int k = N - 1; k >= 0; k--) if (REQ[PW'((m_ptr + k) % N)]) m_owner = (m_ptr + k) % N;
                e_addr = REQ_ADDR[m_owner*AW +: AW];
                e_data = REQ_DATA[m_owner*DW +: DW];
                m_lost = 0; m_hold = 0; m_wait = 0;
                e_txreq = 1'b1;
            end
        end else if (BUS_RESET) m_finish(1);
        else if (m_wait) begin
            if (TX_FAIL) m_finish(1);
            else if (TX_SUCC) m_finish(0);
        end else if (m_hold > 0) begin
            if (!REQ[PW'(m_owner)]) m_withdraw();
            else begin
                m_hold--;
                if (m_hold == 0) e_txreq = 1'b1;
            end
        end else if (ARB_LOST) begin
            if (m_lost == MR) m_finish(1);
            else begin
                m_lost++;
                m_hold = BO;
                e_txreq = 1'b0;
            end
        end else if (TX_ACK) begin
            m_wait = 1;
            e_txreq = 1'b0;
        end else if (!REQ[PW'(m_owner)]) m_withdraw();
        e_gnt = (m_owner < 0) ? '0 : N'(1) << m_owner;
    end

    always @(negedge CLK_IN) begin
        chk("GNT", GNT, e_gnt);
        chk("DONE", DONE, e_done);
        chk("FAIL_OUT", FAIL, e_fail);
        chk("TX_REQ", TX_REQ, e_txreq);
        chk("TX_ADDR", TX_ADDR, e_addr);
        chk("TX_DATA", TX_DATA, e_data);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK_IN);
    endtask

    task automatic wait_txreq(input string nm);
        int n = 0;
        while (TX_REQ !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (TX_REQ !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s wait TX_REQ actual=%b required=1", nm, TX_REQ);
        end
    endtask

    task automatic xfer_ok(input logic [N-1:0] exp, input string nm);
        wait_txreq(nm);
        chk({nm, " grant"}, GNT, exp);
        TX_ACK = 1'b1;
        tick();
        TX_ACK = 1'b0;
        tick(2);
        TX_SUCC = 1'b1;
        tick();
        TX_SUCC = 1'b0;
        chk({nm, " done"}, DONE, exp);
        chk({nm, " gnt drop"}, GNT, '0);
    endtask

    logic [N-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int lows;
        logic [N-1:0] rs, rd;
        RESET = 1'b1; REQ = '0; REQ_ADDR = '0; REQ_DATA = '0;
        TX_ACK = 0; ARB_LOST = 0; TX_SUCC = 0; TX_FAIL = 0; BUS_RESET = 0;
        tick(3);
        chk("reset GNT", GNT, '0);
        chk("reset TX_REQ", TX_REQ, 0);
        chk("reset TX_DATA", TX_DATA, '0);
        RESET = 1'b0;

        // Single request with a late ack and a long result wait.
        REQ = 4'b0001; REQ_ADDR[7:0] = 8'h5A; REQ_DATA[31:0] = 32'hCAFE_0001;
        tick();
        chk("single grant", GNT, 4'b0001);
        chk("single txreq", TX_REQ, 1);
        chk("single addr", TX_ADDR, 8'h5A);
        REQ_ADDR[7:0] = 8'hFF;
        tick(2);
        TX_ACK = 1'b1; tick(); TX_ACK = 1'b0;
        tick(9);
        chk("single addr held", TX_ADDR, 8'h5A);
        TX_SUCC = 1'b1; tick(); TX_SUCC = 1'b0;
        chk("single done", DONE, 4'b0001);
        chk("single gnt drop", GNT, '0);
        REQ = '0;
        tick();
        chk("single done once", DONE, '0);

        // Pointer now 1: requester 1 beats requester 0.
        REQ = 4'b0011;
        tick();
        chk("ptr after single", GNT, 4'b0010);
        xfer_ok(4'b0010, "ptr xfer");
        REQ = '0;
        RESET = 1'b1; tick(); RESET = 1'b0;

        REQ = 4'b1111;
        for (int i = 0; i < 5; i++) xfer_ok(order[i], $sformatf("fair%0d", i));
        REQ = '0;

        // Retry exhaustion, pointer is 1 so requester 2 wins.
        REQ = 4'b0100;
        tick();
        for (int a = 0; a <= MR; a++) begin
            lows = 0;
            while (TX_REQ !== 1'b1 && lows < 64) begin
                tick();
                lows++;
            end
            if (a > 0) chk($sformatf("retry gap%0d", a), lows, BO);
            chk("retry grant", GNT, 4'b0100);
            ARB_LOST = 1'b1; tick(); ARB_LOST = 1'b0;
        end
        chk("retry fail", FAIL, 4'b0100);
        chk("retry no done", DONE, '0);
        REQ = '0;

        // Ack with lost together is a loss; succ with fail together is a failure.
        REQ = 4'b0001;
        tick();
        wait_txreq("simul");
        TX_ACK = 1'b1; ARB_LOST = 1'b1; tick(); TX_ACK = 1'b0; ARB_LOST = 1'b0;
        chk("simul backoff txreq", TX_REQ, 0);
        chk("simul backoff gnt", GNT, 4'b0001);
        wait_txreq("simul retry");
        TX_ACK = 1'b1; tick(); TX_ACK = 1'b0;
        tick();
        TX_SUCC = 1'b1; TX_FAIL = 1'b1; tick(); TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        chk("simul fail", FAIL, 4'b0001);
        chk("simul no done", DONE, '0);
        REQ = '0;

        // Bus reset during the result wait.
        REQ = 4'b0010;
        tick();
        wait_txreq("abort");
        TX_ACK = 1'b1; tick(); TX_ACK = 1'b0;
        tick();
        BUS_RESET = 1'b1;
        tick();
        chk("abort fail", FAIL, 4'b0010);
        chk("abort txreq", TX_REQ, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort no grant", GNT, '0);
        end
        REQ = '0; BUS_RESET = 1'b0;

        // Withdraw during backoff leaves the pointer at 2.
        REQ = 4'b1000;
        tick();
        wait_txreq("withdraw");
        ARB_LOST = 1'b1; tick(); ARB_LOST = 1'b0;
        tick(3);
        REQ = '0;
        tick();
        chk("withdraw gnt", GNT, '0);
        chk("withdraw no pulse", FAIL | DONE, '0);
        REQ = 4'b1001;
        tick();
        chk("withdraw ptr kept", GNT, 4'b1000);
        RESET = 1'b1;
        tick();
        chk("midreset gnt", GNT, '0);
        chk("midreset txreq", TX_REQ, 0);
        chk("midreset pulses", FAIL | DONE, '0);
        RESET = 1'b0;
        tick();
        chk("midreset ptr zero", GNT, 4'b0001);
        REQ = '0;
        tick(2);

        for (int c = 0; c < 4000; c++) begin
            rs = '0;
            rd = '0;
            for (int i = 0; i < N; i++) begin
                rs |= N'($urandom % 8 == 0) << i;
                rd |= N'($urandom % 40 == 0) << i;
            end
            REQ = (REQ & ~(rd | e_done | e_fail)) | (~REQ & rs);
            if ($urandom % 2 == 0) REQ_ADDR = $urandom;
            if ($urandom % 2 == 0) REQ_DATA = {$urandom, $urandom, $urandom, $urandom};
            TX_ACK = ($urandom % 4 == 0);
            ARB_LOST = ($urandom % 8 == 0);
            TX_SUCC = ($urandom % 5 == 0);
            TX_FAIL = ($urandom % 10 == 0);
            BUS_RESET = ($urandom % 60 == 0);
            RESET = ($urandom % 400 == 0);
            tick();
        end
        REQ = '0; TX_ACK = 0; ARB_LOST = 0; TX_SUCC = 0; TX_FAIL = 0; BUS_RESET = 0; RESET = 0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
